// File: rtl/divider_ctrl_pkg.sv
// Shared constants for the sequential restoring divider and its ALU subtractor.
// Holds the FSM state encoding, datapath widths and ALU operation codes.
package divider_ctrl_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_OR  = 2'd3
    } alu_op_e;

endpackage

// File: rtl/divider_ctrl_alu.sv
// Small combinational ALU; the divider uses its SUB path as the trial subtractor.
// For SUB, Carry is the borrow out (1 when Src_1 < Src_2).
module divider_ctrl_alu
    import divider_ctrl_pkg::*;
(
    input  alu_op_e           alu_op,
    input  logic [WIDTH-1:0]  Src_1,
    input  logic [WIDTH-1:0]  Src_2,
    output logic [WIDTH-1:0]  Result,
    output logic              Carry
);

    always_comb begin
        Result = '0;
        Carry  = 1'b0;
        case (alu_op)
            ALU_ADD: {Carry, Result} = {1'b0, Src_1} + {1'b0, Src_2};
            // Zero-extended subtract: bit WIDTH of the difference is the borrow.
            ALU_SUB: {Carry, Result} = {1'b0, Src_1} - {1'b0, Src_2};
            ALU_AND: Result = Src_1 & Src_2;
            ALU_OR:  Result = Src_1 | Src_2;
            default: ;
        endcase
    end

endmodule

// File: rtl/divider_ctrl.sv
// 32-bit unsigned restoring divider: one quotient bit per BUSY cycle, 32 iterations,
// trial subtraction done by the shared ALU; results held until the next accepted start.
module divider_ctrl
    import divider_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  dividend,
    input  logic [WIDTH-1:0]  divisor,
    output logic              ready,
    output logic              done,
    output logic [WIDTH-1:0]  quotient,
    output logic [WIDTH-1:0]  remainder,
    output logic              div_by_zero
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  counter_q, counter_d;
    logic [WIDTH-1:0]  rem_hi_q, rem_hi_d;
    logic [WIDTH-1:0]  rem_lo_q, rem_lo_d;
    logic [WIDTH-1:0]  div_reg_q, div_reg_d;
    logic [WIDTH-1:0]  quotient_q, quotient_d;
    logic [WIDTH-1:0]  remainder_q, remainder_d;
    logic              dbz_q, dbz_d;
    logic              done_q, done_d;

    logic              msb_out;
    logic [WIDTH-1:0]  sh_hi;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_carry;
    logic              success;
    logic              accept;

    // {msb_out, sh_hi, sh_lo} = {rem_hi, rem_lo} << 1; sh_lo is folded into rem_lo_d.
    assign msb_out = rem_hi_q[WIDTH-1];
    assign sh_hi   = {rem_hi_q[WIDTH-2:0], rem_lo_q[WIDTH-1]};

    divider_ctrl_alu u_alu (
        .alu_op (ALU_SUB),
        .Src_1  (sh_hi),
        .Src_2  (div_reg_q),
        .Result (alu_result),
        .Carry  (alu_carry)
    );

    // A shifted-out msb means the partial remainder exceeds any 32-bit divisor;
    // the wrapped ALU result is then still the correct low 32 bits.
    assign success = msb_out | ~alu_carry;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept = start && ready;

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        rem_hi_d    = rem_hi_q;
        rem_lo_d    = rem_lo_q;
        div_reg_d   = div_reg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_BUSY: begin
                rem_hi_d  = success ? alu_result : sh_hi;
                rem_lo_d  = {rem_lo_q[WIDTH-2:0], success};
                counter_d = counter_q + CNT_W'(1);
                if (counter_q == CNT_W'(ITER_LAST)) begin
                    state_d     = S_DONE;
                    quotient_d  = rem_lo_d;
                    remainder_d = rem_hi_d;
                    dbz_d       = (div_reg_q == '0);
                    done_d      = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Accepting from DONE overrides the return to IDLE for back-to-back ops.
        if (accept) begin
            state_d   = S_BUSY;
            rem_hi_d  = '0;
            rem_lo_d  = dividend;
            div_reg_d = divisor;
            counter_d = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            counter_q   <= '0;
            rem_hi_q    <= '0;
            rem_lo_q    <= '0;
            div_reg_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            rem_hi_q    <= rem_hi_d;
            rem_lo_q    <= rem_lo_d;
            div_reg_q   <= div_reg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
